// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: single-clock FIFO backed by a register RAM with a registered read port.
//
// Optional feature: define FIFO_SYNC_RAM_ERR_EN to build sticky overflow/underflow flags.
// Without it, overflow_o/underflow_o are tied to 0 and err_clr_i is ignored.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          synchronous reset, active-low
//   flush_i         synchronous empty (pointers/count cleared, RAM and rdata_o kept)
//   wr_en_i/wdata_i push request and data
//   rd_en_i         pop request
//   rdata_o         popped data, valid one cycle after an accepted pop
//   rvalid_o        rdata_o was updated by the previous cycle's pop
//   full_o, empty_o, almost_full_o, almost_empty_o  status derived from count_o
//   count_o         current occupancy
//   err_clr_i       clears the sticky error flags
//   overflow_o      sticky: a push was rejected
//   underflow_o     sticky: a pop was rejected
module fifo_sync_ram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    localparam int unsigned A_WIDTH   = $clog2(FIFO_DEPTH),
    localparam int unsigned C_WIDTH   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               wr_en_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               rd_en_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               rvalid_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic [C_WIDTH-1:0] count_o,
    input  logic               err_clr_i,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam logic [A_WIDTH-1:0] PTR_LAST = A_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [C_WIDTH-1:0] CNT_FULL = C_WIDTH'(FIFO_DEPTH);
    localparam logic [C_WIDTH-1:0] CNT_AF   = C_WIDTH'(AF_LEVEL);
    localparam logic [C_WIDTH-1:0] CNT_AE   = C_WIDTH'(AE_LEVEL);

    logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [A_WIDTH-1:0] wptr_q, wptr_d;
    logic [A_WIDTH-1:0] rptr_q, rptr_d;
    logic [C_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic full_c, empty_c;
    logic push_ok_c, pop_ok_c;

    // Status flags decode the registered occupancy.
    assign full_c         = (count_q == CNT_FULL);
    assign empty_c        = (count_q == '0);
    assign full_o         = full_c;
    assign empty_o        = empty_c;
    assign almost_full_o  = (count_q >= CNT_AF);
    assign almost_empty_o = (count_q <= CNT_AE);
    assign count_o        = count_q;
    assign rdata_o        = rdata_q;
    assign rvalid_o       = rvalid_q;

    // A full FIFO still takes a push when a pop frees a slot in the same cycle;
    // an empty FIFO never forwards write data straight to the read port.
    assign pop_ok_c  = rd_en_i && !empty_c;
    assign push_ok_c = wr_en_i && (!full_c || pop_ok_c);

    // Next-state for pointers, count and read port.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok_c) begin
                wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + A_WIDTH'(1);
            end
            if (pop_ok_c) begin
                rptr_d   = (rptr_q == PTR_LAST) ? '0 : rptr_q + A_WIDTH'(1);
                rdata_d  = mem_q[rptr_q];
                rvalid_d = 1'b1;
            end
            if (push_ok_c && !pop_ok_c) begin
                count_d = count_q + C_WIDTH'(1);
            end else if (pop_ok_c && !push_ok_c) begin
                count_d = count_q - C_WIDTH'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage array; contents are not reset and survive flush.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && push_ok_c) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

`ifdef FIFO_SYNC_RAM_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: a same-cycle set beats the clear; flush leaves them alone.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush_i && wr_en_i && !push_ok_c) begin
            overflow_d = 1'b1;
        end
        if (!flush_i && rd_en_i && !pop_ok_c) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_ram.sv
// Directed self-checking bench for fifo_sync_ram (WIDTH=8, FIFO_DEPTH=4, AF=3, AE=1).
module tb_fifo_sync_ram;

`ifdef FIFO_SYNC_RAM_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = '0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rdata;
    logic       rvalid, full, empty, afull, aempty, ovf, unf;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    fifo_sync_ram #(.WIDTH(8), .FIFO_DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
        .rdata_o(rdata), .rvalid_o(rvalid),
        .full_o(full), .empty_o(empty),
        .almost_full_o(afull), .almost_empty_o(aempty),
        .count_o(count), .err_clr_i(err_clr),
        .overflow_o(ovf), .underflow_o(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                       input logic f = 1'b0, input logic c = 1'b0);
        wr_en = w; wdata = d; rd_en = r; flush = f; err_clr = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d);
        cyc(1'b0, 8'h00, 1'b1);
        chk({tag, "_rdata"}, 32'(rdata), 32'(d));
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    endtask

    task automatic flags(input string tag, input logic [2:0] c, input logic e,
                         input logic fu, input logic ae, input logic af);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_full"}, 32'(full), 32'(fu));
        chk({tag, "_aempty"}, 32'(aempty), 32'(ae));
        chk({tag, "_afull"}, 32'(afull), 32'(af));
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        flags("rst", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        rst_n = 1'b1;

        // Fill and drain with threshold tracking
        push(8'h11); flags("p1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(8'h22); flags("p2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'h33); flags("p3", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        push(8'h44); flags("p4", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        pop_chk("d1", 8'h11); flags("d1", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_chk("d2", 8'h22); flags("d2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_chk("d3", 8'h33); flags("d3", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_chk("d4", 8'h44); flags("d4", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("idle_rvalid", 32'(rvalid), 32'd0);
        chk("idle_rdata_hold", 32'(rdata), 32'h44);

        // Wrap-around
        push(8'hA1); push(8'hA2); push(8'hA3);
        pop_chk("wa1", 8'hA1); pop_chk("wa2", 8'hA2); pop_chk("wa3", 8'hA3);
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        chk("wrap_full", 32'(full), 32'd1);
        pop_chk("wb1", 8'hB1); pop_chk("wb2", 8'hB2);
        pop_chk("wb3", 8'hB3); pop_chk("wb4", 8'hB4);
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_ovf", 32'(ovf), 32'd0);
        chk("wrap_unf", 32'(unf), 32'd0);

        // Push and pop while full
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        cyc(1'b1, 8'h55, 1'b1);
        chk("pp_rdata", 32'(rdata), 32'hC1);
        chk("pp_rvalid", 32'(rvalid), 32'd1);
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf", 32'(ovf), 32'd0);
        pop_chk("pp2", 8'hC2); pop_chk("pp3", 8'hC3);
        pop_chk("pp4", 8'hC4); pop_chk("pp55", 8'h55);
        chk("pp_empty", 32'(empty), 32'd1);

        // Error flags
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        push(8'h66);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_set", 32'(ovf), 32'(ERR));
        pop_chk("e1", 8'hD1); pop_chk("e2", 8'hD2);
        pop_chk("e3", 8'hD3); pop_chk("e4", 8'hD4);
        cyc(1'b0, 8'h00, 1'b1);
        chk("unf_rvalid", 32'(rvalid), 32'd0);
        chk("unf_rdata_hold", 32'(rdata), 32'hD4);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_set", 32'(unf), 32'(ERR));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("flush_keeps_ovf", 32'(ovf), 32'(ERR));
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_unf", 32'(unf), 32'd0);

        // Flush with same-cycle push
        push(8'hE1); push(8'hE2);
        cyc(1'b1, 8'hE3, 1'b0, 1'b1, 1'b0);
        flags("flush", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_rvalid", 32'(rvalid), 32'd0);
        push(8'hF1);
        pop_chk("after_flush", 8'hF1);
        chk("after_flush_empty", 32'(empty), 32'd1);

        // Reset mid-drain
        push(8'h71); push(8'h72); push(8'h73);
        pop_chk("md1", 8'h71);
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b1);
        flags("mrst", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("mrst_rdata", 32'(rdata), 32'h0);
        chk("mrst_rvalid", 32'(rvalid), 32'd0);
        chk("mrst_ovf", 32'(ovf), 32'd0);
        chk("mrst_unf", 32'(unf), 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_pop_rvalid", 32'(rvalid), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ram.md
FIFO_SYNC_RAM -- requirements
Module: fifo_sync_ram

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits, at least 1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: number of entries, at least 2, any integer (not restricted to power of two).
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1: almost-full threshold, 1..FIFO_DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost-empty threshold, 0..FIFO_DEPTH-1.
REQ-005 SHALL use derived widths A_WIDTH = $clog2(FIFO_DEPTH) and C_WIDTH = $clog2(FIFO_DEPTH+1).
REQ-006 SHALL have ports, in this order:
- clk_i, input, 1: the single clock; all logic on its rising edge.
- rst_ni, input, 1: synchronous reset, active-low.
- flush_i, input, 1: synchronous empty of the FIFO.
- wr_en_i, input, 1: push request.
- wdata_i, input, WIDTH: push data.
- rd_en_i, input, 1: pop request.
- rdata_o, output, WIDTH: popped data.
- rvalid_o, output, 1: rdata_o updated this cycle.
- full_o, output, 1: count_o == FIFO_DEPTH.
- empty_o, output, 1: count_o == 0.
- almost_full_o, output, 1: count_o >= AF_LEVEL.
- almost_empty_o, output, 1: count_o <= AE_LEVEL.
- count_o, output, C_WIDTH: current occupancy.
- err_clr_i, input, 1: clears sticky error flags.
- overflow_o, output, 1: sticky flag, push rejected.
- underflow_o, output, 1: sticky flag, pop rejected.

Function
REQ-007 SHALL store entries in a RAM array with write pointer wptr and read pointer rptr, each wrapping from FIFO_DEPTH-1 to 0.
REQ-008 SHALL accept a push when wr_en_i=1 and either (a) full_o=0, or (b) full_o=1 and a pop is accepted in the same cycle.
REQ-009 SHALL accept a pop when rd_en_i=1 and empty_o=0; an empty FIFO SHALL NOT bypass same-cycle write data.
REQ-010 SHALL, on an accepted push, write wdata_i to RAM[wptr] and advance wptr at the clock edge.
REQ-011 SHALL, on an accepted pop, register RAM[rptr] into rdata_o, advance rptr and assert rvalid_o in the following cycle: one-cycle read latency.
REQ-012 SHALL keep rdata_o unchanged when no pop is accepted; rvalid_o SHALL then be 0.
REQ-013 SHALL update count_o as follows: +1 for a push only, -1 for a pop only, unchanged for both or neither.
REQ-014 SHALL derive full_o, empty_o, almost_full_o and almost_empty_o combinationally from the registered count_o.
REQ-015 SHALL, on flush_i=1, set wptr, rptr and count_o to 0 and rvalid_o to 0, ignoring same-cycle push and pop; RAM contents and rdata_o SHALL be retained.
REQ-016 SHALL give rst_ni priority over flush_i, and flush_i priority over push and pop.

Reset
REQ-017 SHALL, on rising clk_i with rst_ni=0, reset wptr, rptr and count_o to 0, rdata_o to 0, rvalid_o to 0, overflow_o to 0 and underflow_o to 0.
REQ-018 SHALL reset to the following output values: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AF_LEVEL==0 ? 1 : 0), which is 0 for legal AF_LEVEL.
REQ-019 SHALL leave RAM contents undefined after reset; a reset during a burst SHALL discard all entries and any pending read.

Configuration
REQ-020 SHALL compile the error-flag logic only when macro FIFO_SYNC_RAM_ERR_EN is defined.
REQ-021 SHALL, with FIFO_SYNC_RAM_ERR_EN defined:
- set overflow_o when wr_en_i=1 and the push is rejected;
- set underflow_o when rd_en_i=1 and the pop is rejected;
- clear both flags on err_clr_i=1, with a same-cycle set winning over the clear;
- not change either flag on flush_i.
REQ-022 SHALL, without FIFO_SYNC_RAM_ERR_EN, tie overflow_o and underflow_o to 0 and ignore err_clr_i; all other behaviour SHALL be identical.

Verification (WIDTH=8, FIFO_DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-023 Fill and drain: push 0x11,0x22,0x33,0x44, then pop 4 times -> full_o=1 after the 4th push; rdata_o=0x11,0x22,0x33,0x44 each with rvalid_o=1 one cycle after its pop; empty_o=1 at the end.
REQ-024 Wrap-around: push 3, pop 3, push 4, pop 4 -> all data returned in order; count_o returns to 0; no error flags set.
REQ-025 Push and pop while full: with 4 entries held, wr_en_i=rd_en_i=1 with 0x55 -> count_o stays 4; oldest entry popped; 0x55 read as the 4th subsequent pop; overflow_o=0.
REQ-026 Errors (macro defined): push 0x66 while full without pop -> overflow_o=1, data dropped; pop while empty -> underflow_o=1, rvalid_o=0; err_clr_i -> both flags 0.
REQ-027 Flush and reset: flush_i with 2 entries and a same-cycle push -> count_o=0 and empty_o=1 next cycle; rst_ni=0 mid-drain -> all outputs at their REQ-017/018 values.
REQ-028 Thresholds: count 0->4->0 -> almost_full_o=1 at count 3 and 4; almost_empty_o=1 at count 0 and 1.
